// File: rtl/aes_pkg.sv
// +--------------------------------------------------------------------+
// | aes_pkg: shared AES byte type, S-box tables/lookups and FSM states |
// | Optional: SUBBYTES_INV_EN adds the inverse S-box. Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int AES_BYTES = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox_fwd(input byte_t x);
    return SBOX_FWD[(255 - int'(x)) * 8 +: 8];
  endfunction

`ifdef SUBBYTES_INV_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic byte_t sbox_inv(input byte_t x);
    return SBOX_INV[(255 - int'(x)) * 8 +: 8];
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// +--------------------------------------------------------------------+
// | aes_sbox: single-byte S-box lane (forward, or selectable inverse)  |
// | Optional: SUBBYTES_INV_EN adds the inv select. Rev 1.0             |
// +--------------------------------------------------------------------+
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  byte_t din,
`ifdef SUBBYTES_INV_EN
  input  logic  inv,
`endif
  output byte_t dout
);

  always_comb begin
`ifdef SUBBYTES_INV_EN
    dout = inv ? sbox_inv(din) : sbox_fwd(din);
`else
    dout = sbox_fwd(din);
`endif
  end

endmodule

`default_nettype wire

// File: rtl/sub_bytes_seq.sv
// +--------------------------------------------------------------------+
// | sub_bytes_seq: iterative AES SubBytes, LANES bytes per cycle       |
// | Optional: SUBBYTES_INV_EN adds the inv port. Rev 1.0               |
// +--------------------------------------------------------------------+
`default_nettype none

module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SUBBYTES_INV_EN
  input  logic         inv,
`endif
  output logic [127:0] dout
);

  localparam int NCYC = AES_BYTES / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  generate
    if (LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must be 4, 8 or 16");
    end
  endgenerate

  fsm_state_t     state;
  fsm_state_t     state_next;
  logic [CW-1:0]  cnt;
  logic [127:0]   buffer;
  logic [127:0]   buf_sub;
  logic           accept;
  int             lane_base;
  byte_t          lane_in  [LANES];
  byte_t          lane_out [LANES];
`ifdef SUBBYTES_INV_EN
  logic           inv_q;
`endif

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign dout      = buffer;

  // With a single substitution cycle every lane always maps to its own byte.
  assign lane_base = (NCYC == 1) ? 0 : int'(cnt) * LANES;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = buffer[8*(lane_base + l) +: 8];
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      aes_sbox u_sbox (
        .din  (lane_in[l]),
`ifdef SUBBYTES_INV_EN
        .inv  (inv_q),
`endif
        .dout (lane_out[l])
      );
    end
  endgenerate

  always_comb begin
    buf_sub = buffer;
    for (int l = 0; l < LANES; l++) begin
      buf_sub[8*(lane_base + l) +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt == CNT_LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer <= '0;
      cnt    <= '0;
`ifdef SUBBYTES_INV_EN
      inv_q  <= 1'b0;
`endif
    end else if (accept) begin
      buffer <= din;
      cnt    <= '0;
`ifdef SUBBYTES_INV_EN
      inv_q  <= inv;
`endif
    end else if (state == BUSY) begin
      buffer <= buf_sub;
      cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
// +--------------------------------------------------------------------+
// | tb_sub_bytes_seq: randomized bench with a GF(2^8) reference model  |
// | Optional: SUBBYTES_INV_EN exercises the inv port. Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sub_bytes_seq;

  localparam int LANES = 4;
  localparam int NCYC  = 16 / LANES;

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
`ifdef SUBBYTES_INV_EN
  logic         inv;
`endif

  sub_bytes_seq #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SUBBYTES_INV_EN
    .inv       (inv),
`endif
    .dout      (dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-boxes derived from the field inverse plus affine map.
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_tables();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] iv8 = 8'h00;
      logic [7:0] s;
      if (a != 0) begin
        for (int b = 1; b < 256; b++) begin
          if (gmul(8'(a), 8'(b)) == 8'h01) iv8 = 8'(b);
        end
      end
      s = iv8 ^ rotl(iv8, 1) ^ rotl(iv8, 2) ^ rotl(iv8, 3) ^ rotl(iv8, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input bit use_inv);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) begin
      r[8*b +: 8] = use_inv ? inv_tab[d[8*b +: 8]] : fwd_tab[d[8*b +: 8]];
    end
    return r;
  endfunction

  // Transaction-level model: a pending block becomes visible NCYC edges after acceptance.
  int           n         = 0;
  bit           known     = 0;
  bit           pend      = 0;
  int           ready_at  = 0;
  logic [127:0] exp_val   = '0;
  bit           dout_zero = 0;

  task automatic cycle(input bit iv, input bit ordy, input logic [127:0] d, input bit r, input bit iinv);
    bit ev;
    bit er;
    bit use_inv;
    in_valid  = iv;
    out_ready = ordy;
    din       = d;
    rst       = r;
`ifdef SUBBYTES_INV_EN
    inv       = iinv;
    use_inv   = iinv;
`else
    use_inv   = 1'b0;
`endif
    #1;
    ev = pend && (n >= ready_at);
    er = !pend || (ev && ordy);
    if (known) begin
      check("out_valid", 128'(out_valid), 128'(ev));
      check("in_ready", 128'(in_ready), 128'(er));
      if (ev) check("dout", dout, exp_val);
      else if (dout_zero) check("dout_reset", dout, '0);
    end
    @(posedge clk);
    n++;
    if (r) begin
      pend      = 0;
      dout_zero = 1;
      known     = 1;
    end else if (known) begin
      if (ev && ordy) pend = 0;
      if (iv && er) begin
        pend      = 1;
        ready_at  = n + NCYC;
        exp_val   = ref_sub(d, use_inv);
        dout_zero = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_vector(input logic [127:0] d, input bit iinv, input logic [127:0] lit, input string tag);
    cycle(1, 0, d, 0, iinv);
    for (int i = 0; i < NCYC; i++) cycle(0, 0, '0, 0, !iinv);
    #1;
    check({tag, "_valid"}, 128'(out_valid), 128'(1));
    check(tag, dout, lit);
    cycle(0, 1, '0, 0, 0);
  endtask

  initial begin
    in_valid  = 0;
    out_ready = 0;
    din       = '0;
    rst       = 1;
`ifdef SUBBYTES_INV_EN
    inv       = 0;
`endif
    build_tables();
    @(negedge clk);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 0);

    run_vector(FIPS_IN, 0, FIPS_OUT, "fips");
    run_vector('0, 0, {16{8'h63}}, "zero");
    run_vector({16{8'h53}}, 0, {16{8'hed}}, "all53");
`ifdef SUBBYTES_INV_EN
    run_vector({16{8'h63}}, 1, '0, "inv63");
    run_vector(FIPS_OUT, 1, FIPS_IN, "inv_fips");
`endif

    // Backpressure, then pop and accept on the same edge.
    cycle(1, 0, {4{32'hdeadbeef}}, 0, 0);
    for (int i = 0; i < NCYC + 10; i++) cycle(1, 0, 128'h1, 0, 0);
    cycle(1, 1, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 0, 0);
    for (int i = 0; i < NCYC + 1; i++) cycle(0, 1, '0, 0, 0);

    // Reset while BUSY with cnt=2.
    cycle(1, 0, FIPS_IN, 0, 0);
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 1, 0);
    for (int i = 0; i < NCYC + 2; i++) cycle(0, 1, '0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1);
    end
    cycle(0, 1, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
